// File: rtl/dot_update_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : dot_update_scheduler_if
//  Description : Processor MMIO store path, VGA blanking flag, VGA dot-register
//                write port and status-word read path of the dot scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dot_update_scheduler_if;
    // Processor store path
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    // VGA timing
    logic        vblank;
    // VGA dot-location write port
    logic        dot_wren;
    logic        dot_is_y;
    logic [8:0]  dot_id;
    logic [31:0] dot_loc;
    // Status word read path
    logic        status_sel;
    logic [31:0] status_data;

    // System side: drives stores and vblank, observes dot writes and status
    modport master (
        output mem_wren, mem_addr, mem_data, vblank,
        input  dot_wren, dot_is_y, dot_id, dot_loc, status_sel, status_data
    );

    // Scheduler side
    modport slave (
        input  mem_wren, mem_addr, mem_data, vblank,
        output dot_wren, dot_is_y, dot_id, dot_loc, status_sel, status_data
    );
endinterface
`default_nettype wire

// File: rtl/dot_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dot_update_scheduler
//  Description : Captures processor stores to the dot-location window into a
//                FIFO and releases committed batches to the VGA dot registers
//                one entry per cycle, only during vertical blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_update_scheduler #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned X_BASE      = 100,
    parameter int unsigned Y_BASE      = 550,
    parameter int unsigned WIN_END     = 999,
    parameter int unsigned STATUS_ADDR = 1000,
    parameter int unsigned LOC_W       = 16
) (
    input logic                   clock,
    input logic                   reset,
    dot_update_scheduler_if.slave bus
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam int unsigned c_ENT_W = 1 + 9 + LOC_W;

    localparam logic [31:0]        c_X_BASE      = 32'(X_BASE);
    localparam logic [31:0]        c_Y_BASE      = 32'(Y_BASE);
    localparam logic [31:0]        c_WIN_END     = 32'(WIN_END);
    localparam logic [31:0]        c_STATUS_ADDR = 32'(STATUS_ADDR);
    // Window addresses are below 1024 and IDs below 512, so the ID can be
    // formed with 9-bit modular subtraction on the low address bits.
    localparam logic [8:0]         c_X_ID_BASE   = 9'(X_BASE);
    localparam logic [8:0]         c_Y_ID_BASE   = 9'(Y_BASE);
    localparam logic [c_CNT_W-1:0] c_DEPTH       = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE     = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO    = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Storage and bookkeeping
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_commit_cnt;
    logic               r_overflow;
    logic               r_split;
    logic               r_vblank_d;
    state_t             r_state;
    state_t             w_state_nxt;

    // Registered dot write port
    logic               r_dot_wren;
    logic               r_dot_is_y;
    logic [8:0]         r_dot_id;
    logic [31:0]        r_dot_loc;

    // Decode and control wires
    logic               w_in_win;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_is_y;
    logic [8:0]         w_id;
    logic               w_ctrl_wr;
    logic               w_commit;
    logic               w_clear;
    logic               w_vblank_rise;
    logic               w_set_split;
    logic [c_CNT_W-1:0] w_push_ext;
    logic [c_CNT_W-1:0] w_pop_ext;
    logic [c_CNT_W-1:0] w_count_after_pop;
    logic [c_CNT_W-1:0] w_commit_nxt;
    logic [c_ENT_W-1:0] w_head;
    logic [c_ENT_W-1:0] w_new_entry;

    // ------------------------------------------------------------------
    // Address decode of the processor store
    // ------------------------------------------------------------------
    assign w_in_win    = (bus.mem_addr >= c_X_BASE) && (bus.mem_addr <= c_WIN_END);
    assign w_push_req  = bus.mem_wren && w_in_win;
    assign w_is_y      = (bus.mem_addr >= c_Y_BASE);
    assign w_id        = bus.mem_addr[8:0] - (w_is_y ? c_Y_ID_BASE : c_X_ID_BASE);
    assign w_new_entry = {w_is_y, w_id, bus.mem_data[LOC_W-1:0]};

    assign bus.status_sel = (bus.mem_addr == c_STATUS_ADDR);
    assign w_ctrl_wr      = bus.mem_wren && bus.status_sel;
    assign w_commit       = w_ctrl_wr && bus.mem_data[0];
    assign w_clear        = w_ctrl_wr && bus.mem_data[1];

    // Store data bits above the stored location width are not kept
    generate
        if (LOC_W < 32) begin : g_unused_data
            logic w_unused_hi;
            assign w_unused_hi = ^bus.mem_data[31:LOC_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO occupancy, push/pop qualification and commit bookkeeping
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == c_CNT_ZERO);

    // A store into a full FIFO is dropped even if an entry leaves this cycle
    assign w_push = w_push_req && !w_full;

    // Pops only happen in DRAIN, while blanking is live and work is committed
    assign w_pop  = (r_state == S_DRAIN) && bus.vblank && (r_commit_cnt != c_CNT_ZERO);

    assign w_push_ext        = {{(c_CNT_W-1){1'b0}}, w_push};
    assign w_pop_ext         = {{(c_CNT_W-1){1'b0}}, w_pop};
    assign w_count_after_pop = r_count - w_pop_ext;

    // A commit snapshots everything already queued (not this cycle's push)
    assign w_commit_nxt = w_commit ? w_count_after_pop : (r_commit_cnt - w_pop_ext);

    assign w_vblank_rise = bus.vblank && !r_vblank_d;
    assign w_head        = r_mem[r_rd_ptr];

    // Next-state logic for the drain scheduler
    always_comb begin
        w_state_nxt = r_state;
        w_set_split = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_commit_cnt != c_CNT_ZERO) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (r_commit_cnt == c_CNT_ZERO) begin
                    w_state_nxt = S_IDLE;
                end else if (w_vblank_rise) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.vblank) begin
                    // Blanking ended before the batch finished
                    if (r_commit_cnt != c_CNT_ZERO) begin
                        w_state_nxt = S_ARMED;
                        w_set_split = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_commit_nxt == c_CNT_ZERO) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and previous-vblank register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_vblank_d <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vblank_d <= bus.vblank;
        end
    end

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + w_push_ext - w_pop_ext;
        end
    end

    // Committed-entry counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_commit_cnt <= '0;
        end else begin
            r_commit_cnt <= w_commit_nxt;
        end
    end

    // Sticky overflow and split flags, cleared by a control write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_split    <= 1'b0;
        end else begin
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clear) begin
                r_overflow <= 1'b0;
            end
            if (w_set_split) begin
                r_split <= 1'b1;
            end else if (w_clear) begin
                r_split <= 1'b0;
            end
        end
    end

    // Registered dot write port; data fields hold between pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dot_wren <= 1'b0;
            r_dot_is_y <= 1'b0;
            r_dot_id   <= '0;
            r_dot_loc  <= '0;
        end else begin
            r_dot_wren <= w_pop;
            if (w_pop) begin
                r_dot_is_y <= w_head[c_ENT_W-1];
                r_dot_id   <= w_head[LOC_W +: 9];
                r_dot_loc  <= 32'(w_head[LOC_W-1:0]);
            end
        end
    end

    assign bus.dot_wren    = r_dot_wren;
    assign bus.dot_is_y    = r_dot_is_y;
    assign bus.dot_id      = r_dot_id;
    assign bus.dot_loc     = r_dot_loc;

    assign bus.status_data = {10'd0, r_state, r_split, r_overflow, w_full, w_empty,
                              8'(r_commit_cnt), 8'(r_count)};

endmodule
`default_nettype wire

// File: tb/tb_dot_update_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dot_update_scheduler
//  Description : Self-checking bench for dot_update_scheduler: decode vector
//                table, directed batch/overflow/split/late-commit/reset
//                sequences and a randomized run against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_update_scheduler;

    localparam int c_DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dot_update_scheduler_if bus();

    dot_update_scheduler #(.DEPTH(c_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        is_y;
        logic [8:0]  id;
        logic [31:0] loc;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_sel;
        bit          exp_push;
    } vec_t;

    // Reference model: queued dot writes, committed count, overflow flag
    ent_t mq[$];
    int   m_commit   = 0;
    bit   m_overflow = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    int   cyc      = 0;
    int   pulse_cyc[$];
    logic vb_at_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        vb_at_edge = bus.vblank;
    end

    // Each dot write must be the oldest committed entry, issued during blanking
    always @(negedge clock) begin : mon
        ent_t e;
        if (bus.dot_wren === 1'b1) begin
            n_pulses++;
            pulse_cyc.push_back(cyc);
            chk("pulse_in_vblank", 32'(vb_at_edge), 32'd1);
            if (mq.size() == 0 || m_commit <= 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got is_y=%0d id=%0d loc=0x%0h expected no write",
                         bus.dot_is_y, bus.dot_id, bus.dot_loc);
            end else begin
                e = mq.pop_front();
                m_commit--;
                chk("pulse_is_y", 32'(bus.dot_is_y), 32'(e.is_y));
                chk("pulse_id",   32'(bus.dot_id),   32'(e.id));
                chk("pulse_loc",  bus.dot_loc,       e.loc);
            end
        end
    end

    // Model of one processor store, from the address-map rules
    task automatic model_store(input logic [31:0] addr, input logic [31:0] data);
        ent_t e;
        if (addr >= 32'd100 && addr <= 32'd999) begin
            if (mq.size() >= c_DEPTH) begin
                m_overflow = 1'b1;
            end else begin
                e.is_y = (addr >= 32'd550);
                e.id   = e.is_y ? 9'(addr - 32'd550) : 9'(addr - 32'd100);
                e.loc  = {16'h0000, data[15:0]};
                mq.push_back(e);
            end
        end else if (addr == 32'd1000) begin
            if (data[0]) m_commit = mq.size();
            if (data[1]) m_overflow = 1'b0;
        end
    endtask

    // One-cycle store; called at a negedge, returns at the next negedge
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_wren = 1'b1;
        bus.mem_addr = addr;
        bus.mem_data = data;
        model_store(addr, data);
        @(negedge clock);
        bus.mem_wren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic vb_pulse(input int hi, input int lo);
        bus.vblank = 1'b1;
        repeat (hi) @(negedge clock);
        bus.vblank = 1'b0;
        idle(lo);
    endtask

    task automatic chk_status(input string tag, input int exp_state);
        #1;
        chk({tag, "_count"},    32'(bus.status_data[7:0]),   32'(mq.size()));
        chk({tag, "_commit"},   32'(bus.status_data[15:8]),  32'(m_commit));
        chk({tag, "_empty"},    32'(bus.status_data[16]),    32'(mq.size() == 0));
        chk({tag, "_full"},     32'(bus.status_data[17]),    32'(mq.size() == c_DEPTH));
        chk({tag, "_overflow"}, 32'(bus.status_data[18]),    32'(m_overflow));
        chk({tag, "_state"},    32'(bus.status_data[21:20]), 32'(exp_state));
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        mq.delete();
        m_commit   = 0;
        m_overflow = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vec_t vecs[9];
        int   tbl_cnt;
        int   n0;
        int   n_rand_push;

        vecs[0] = '{32'd99,        32'd1,         1'b0, 1'b0};
        vecs[1] = '{32'd100,       32'h11,        1'b0, 1'b1};
        vecs[2] = '{32'd549,       32'hABCD1234,  1'b0, 1'b1};
        vecs[3] = '{32'd550,       32'h22,        1'b0, 1'b1};
        vecs[4] = '{32'd999,       32'hFFFF,      1'b0, 1'b1};
        vecs[5] = '{32'd1000,      32'd0,         1'b1, 1'b0};
        vecs[6] = '{32'd1001,      32'd5,         1'b0, 1'b0};
        vecs[7] = '{32'h0001_0064, 32'd6,         1'b0, 1'b0};
        vecs[8] = '{32'd777,       32'h8000_0042, 1'b0, 1'b1};

        bus.mem_wren = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_data = 32'd0;
        bus.vblank   = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Reset state
        chk("rst_dot_wren", 32'(bus.dot_wren), 32'd0);
        chk("rst_dot_is_y", 32'(bus.dot_is_y), 32'd0);
        chk("rst_dot_id",   32'(bus.dot_id),   32'd0);
        chk("rst_dot_loc",  bus.dot_loc,       32'd0);
        chk("rst_status",   bus.status_data,   32'h0001_0000);

        // Basic batch: two back-to-back writes during one blanking interval
        n0 = n_pulses;
        store(32'd105, 32'd7);
        store(32'd560, 32'd9);
        store(32'd1000, 32'd1);
        idle(3);
        vb_pulse(20, 2);
        chk("basic_pulses", 32'(n_pulses - n0), 32'd2);
        if (pulse_cyc.size() >= 2) begin
            chk("basic_b2b", 32'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 32'd1);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL basic_b2b: got %0d pulses expected 2", pulse_cyc.size());
        end
        chk("basic_hold_is_y", 32'(bus.dot_is_y), 32'd1);
        chk("basic_hold_id",   32'(bus.dot_id),   32'd10);
        chk("basic_hold_loc",  bus.dot_loc,       32'd9);
        chk_status("basic", 0);

        // Decode vector table
        tbl_cnt = 0;
        n0 = n_pulses;
        for (int i = 0; i < 9; i++) begin
            bus.mem_addr = vecs[i].addr;
            #1;
            chk($sformatf("tbl%0d_sel", i), 32'(bus.status_sel), 32'(vecs[i].exp_sel));
            store(vecs[i].addr, vecs[i].data);
            tbl_cnt += int'(vecs[i].exp_push);
            #1;
            chk($sformatf("tbl%0d_count", i), 32'(bus.status_data[7:0]), 32'(tbl_cnt));
        end
        store(32'd1000, 32'd1);
        idle(3);
        vb_pulse(20, 2);
        chk("tbl_pulses", 32'(n_pulses - n0), 32'(tbl_cnt));
        chk_status("tbl", 0);

        // No commit: stores stay queued through blanking
        n0 = n_pulses;
        store(32'd200, 32'd1);
        store(32'd600, 32'd2);
        store(32'd300, 32'd3);
        idle(2);
        vb_pulse(8, 5);
        vb_pulse(8, 5);
        chk("nocommit_pulses", 32'(n_pulses - n0), 32'd0);
        chk_status("nocommit", 0);
        do_reset();

        // Overflow: 18 stores into 16 entries
        for (int i = 0; i < 18; i++) store(32'(100 + i), 32'(i + 1));
        chk_status("ovf", 0);
        n0 = n_pulses;
        store(32'd1000, 32'd1);
        idle(3);
        vb_pulse(30, 2);
        chk("ovf_pulses", 32'(n_pulses - n0), 32'd16);
        store(32'd1000, 32'd2);
        chk_status("ovf_clear", 0);

        // Split drain: 10 committed, blanking lasts 4 cycles
        for (int i = 0; i < 10; i++) store(32'(300 + i), 32'(16'h100 + i));
        store(32'd1000, 32'd1);
        idle(3);
        n0 = n_pulses;
        vb_pulse(4, 3);
        chk("split_first_pulses", 32'(n_pulses - n0), 32'd3);
        chk("split_flag", 32'(bus.status_data[19]), 32'd1);
        chk_status("split_mid", 1);
        vb_pulse(20, 2);
        chk("split_total_pulses", 32'(n_pulses - n0), 32'd10);
        chk_status("split_end", 0);
        store(32'd1000, 32'd2);
        #1;
        chk("split_clear", 32'(bus.status_data[19]), 32'd0);

        // Late commit while blanking is already high, then push during drain
        store(32'd400, 32'h31);
        store(32'd900, 32'h32);
        n0 = n_pulses;
        bus.vblank = 1'b1;
        idle(3);
        store(32'd1000, 32'd1);
        idle(10);
        chk("late_no_pulses", 32'(n_pulses - n0), 32'd0);
        chk_status("late_armed", 1);
        bus.vblank = 1'b0;
        idle(3);
        bus.vblank = 1'b1;
        store(32'd410, 32'h41);
        store(32'd411, 32'h42);
        #1;
        chk("conc_count_mid", 32'(bus.status_data[7:0]), 32'(mq.size()));
        store(32'd412, 32'h43);
        idle(10);
        bus.vblank = 1'b0;
        idle(3);
        chk("conc_pulses", 32'(n_pulses - n0), 32'd2);
        chk_status("conc", 0);
        do_reset();

        // Reset in the middle of a drain
        for (int i = 0; i < 6; i++) store(32'(700 + i), 32'(i));
        store(32'd1000, 32'd1);
        idle(3);
        bus.vblank = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        mq.delete();
        m_commit   = 0;
        m_overflow = 1'b0;
        n0 = n_pulses;
        @(negedge clock);
        #1;
        chk("rstmid_dot_wren", 32'(bus.dot_wren), 32'd0);
        chk("rstmid_status",   bus.status_data,   32'h0001_0000);
        reset = 1'b0;
        bus.vblank = 1'b0;
        idle(4);
        vb_pulse(10, 3);
        chk("rstmid_pulses", 32'(n_pulses - n0), 32'd0);

        // Randomized traffic against the queue model
        n0 = n_pulses;
        n_rand_push = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            bus.vblank = ((i % 50) >= 35) && ((i % 50) < 47);
            r = int'($urandom_range(0, 99));
            if (!bus.vblank && r < 8) begin
                store(32'd1000, 32'd1);
            end else if (r < 50 && mq.size() < c_DEPTH) begin
                store(32'(100 + $urandom_range(0, 899)), $urandom);
                n_rand_push++;
            end else begin
                @(negedge clock);
            end
            if ((i % 100) == 99) begin
                #1;
                chk("rand_count",  32'(bus.status_data[7:0]),  32'(mq.size()));
                chk("rand_commit", 32'(bus.status_data[15:8]), 32'(m_commit));
            end
        end
        bus.vblank = 1'b0;
        idle(2);
        store(32'd1000, 32'd3);
        idle(3);
        vb_pulse(25, 3);
        chk("rand_pulses", 32'(n_pulses - n0), 32'(n_rand_push));
        chk_status("rand_end", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
